// File: rtl/fitof_pipe.sv
// fitof_pipe -- 3-stage pipelined signed 32-bit integer to IEEE-754 single
// precision conversion for the VLIW FPU slot. Its latency matches the add/sub
// pipe, so the issue logic sees a single FPU latency.
//
// Pipeline:
//   stage 1  sign, magnitude and zero flag of the operand
//   stage 2  leading-zero count, normalisation and biased exponent
//   stage 3  mantissa extraction, rounding, registered result
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset; clears valids and data
//   in_valid_i   x_i carries an operand this cycle
//   x_i          two's-complement signed integer operand
//   stall_i      freezes every pipeline register; the operand offered
//                during a stall is not taken
//   out_valid_o  y_o holds a new result this cycle
//   y_o          single-precision result {sign, exp[7:0], mant[22:0]}
//   inexact_o    result differs from x_i; qualified by out_valid_o
//
// Build option:
//   FITOF_ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                           undefined -> round toward zero (truncate)
//   inexact_o is reported in both builds.

module fitof_pipe #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic [31:0] x_i,
  input  logic        stall_i,
  output logic        out_valid_o,
  output logic [31:0] y_o,
  output logic        inexact_o
);

  // The pipeline depth is structural; only the value 3 is meaningful.
  if (LATENCY != 3) begin : gBadLatency
    $error("fitof_pipe: LATENCY must be 3");
  end

  // ---------------------------------------------------------------- stage 1
  logic        s1Valid_q, s1Sign_q, s1Zero_q;
  logic [31:0] s1Mag_q;
  logic [31:0] s1Mag_d;

  // Negating 32'h80000000 wraps to itself, which is the correct unsigned
  // magnitude, so no special case is needed.
  assign s1Mag_d = x_i[31] ? (~x_i + 32'd1) : x_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= 1'b0;
      s1Zero_q  <= 1'b0;
      s1Mag_q   <= 32'd0;
    end else if (!stall_i) begin
      s1Valid_q <= in_valid_i;
      s1Sign_q  <= x_i[31];
      s1Zero_q  <= (x_i == 32'd0);
      s1Mag_q   <= s1Mag_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic        s2Valid_q, s2Sign_q, s2Zero_q;
  logic [30:0] s2Norm_q;
  logic [7:0]  s2Exp_q;
  logic [4:0]  lzCount;
  logic [30:0] s2Norm_d;
  logic [7:0]  s2Exp_d;

  // Priority encoder: scanning upward lets the highest set bit win. A zero
  // magnitude yields 31; the zero flag overrides the result later anyway.
  always_comb begin
    lzCount = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (s1Mag_q[i]) lzCount = 5'(31 - i);
    end
  end

  // After normalisation bit 31 is the implicit one, so it is not stored.
  assign s2Norm_d = 31'(s1Mag_q << lzCount);
  assign s2Exp_d  = 8'd158 - {3'd0, lzCount};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Sign_q  <= 1'b0;
      s2Zero_q  <= 1'b0;
      s2Norm_q  <= 31'd0;
      s2Exp_q   <= 8'd0;
    end else if (!stall_i) begin
      s2Valid_q <= s1Valid_q;
      s2Sign_q  <= s1Sign_q;
      s2Zero_q  <= s1Zero_q;
      s2Norm_q  <= s2Norm_d;
      s2Exp_q   <= s2Exp_d;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic        outValid_q, inexact_q;
  logic [31:0] y_q;
  logic [22:0] mant, mantRnd;
  logic [7:0]  expRnd;
  logic        guardBit, stickyBit;
  logic [31:0] yResult_d;
  logic        inexact_d;

  assign mant      = s2Norm_q[30:8];
  assign guardBit  = s2Norm_q[7];
  assign stickyBit = |s2Norm_q[6:0];

`ifdef FITOF_ROUND_NEAREST_EN
  logic        roundUp;
  logic [23:0] mantSum;

  // Ties go to the even mantissa. A carry out of the mantissa means it
  // wrapped to zero and the value moved up one binade; the exponent is at
  // most 158 here, so it can never overflow.
  assign roundUp = guardBit & (stickyBit | mant[0]);
  assign mantSum = {1'b0, mant} + {23'd0, roundUp};
  assign mantRnd = mantSum[22:0];
  assign expRnd  = s2Exp_q + {7'd0, mantSum[23]};
`else
  assign mantRnd = mant;
  assign expRnd  = s2Exp_q;
`endif

  // Zero input always produces +0 and is exact.
  assign yResult_d = s2Zero_q ? 32'd0 : {s2Sign_q, expRnd, mantRnd};
  assign inexact_d = ~s2Zero_q & (guardBit | stickyBit);

  // Bubbles leave y/inexact holding their previous result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      y_q        <= 32'd0;
      inexact_q  <= 1'b0;
    end else if (!stall_i) begin
      outValid_q <= s2Valid_q;
      if (s2Valid_q) begin
        y_q       <= yResult_d;
        inexact_q <= inexact_d;
      end
    end
  end

  assign out_valid_o = outValid_q;
  assign y_o         = y_q;
  assign inexact_o   = inexact_q;

endmodule
